// File: rtl/writeback.sv
// Final pipeline stage: M/W register feeding register-file write, forwarding tap and commit port.
// It also keeps the retired-instruction counter and the sticky halt flag.
module writeback #(
   parameter int XLEN    = 64,
   parameter int REGADDR = 5
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               in_valid,
   input  logic [XLEN-1:0]    in_pc,
   input  logic [XLEN-1:0]    in_result,
   input  logic [REGADDR-1:0] in_rd,
   input  logic               in_regwrite,
   input  logic               in_addr31,
   input  logic               in_halt,
   input  logic               hold,
   input  logic               flush,
   output logic               rf_we,
   output logic [REGADDR-1:0] rf_wa,
   output logic [XLEN-1:0]    rf_wd,
   output logic               fwd_valid,
   output logic [REGADDR-1:0] fwd_rd,
   output logic [XLEN-1:0]    fwd_data,
   output logic               commit_valid,
   output logic [XLEN-1:0]    commit_pc,
   output logic               commit_skip,
   output logic [XLEN-1:0]    instret,
   output logic               halted
);

   localparam logic [XLEN-1:0] ONE = XLEN'(1);

   logic               r_v;
   logic [XLEN-1:0]    r_pc;
   logic [XLEN-1:0]    r_result;
   logic [REGADDR-1:0] r_rd;
   logic               r_regwrite;
   logic               r_addr31;
   logic               r_halt;
   logic               r_done;
   logic [XLEN-1:0]    r_instret;
   logic               r_halted;

   logic w_live;
   logic w_rd_nz;
   logic w_stop;

   assign w_live  = r_v & ~r_done;
   assign w_rd_nz = (r_rd != '0);
   // A retiring halt already blocks the capture at its own closing edge, so
   // nothing behind it can become live once halted is visible.
   assign w_stop  = r_halted | (w_live & r_halt);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_v        <= 1'b0;
         r_pc       <= '0;
         r_result   <= '0;
         r_rd       <= '0;
         r_regwrite <= 1'b0;
         r_addr31   <= 1'b0;
         r_halt     <= 1'b0;
         r_done     <= 1'b0;
         r_instret  <= '0;
         r_halted   <= 1'b0;
      end else begin
         if (w_live) begin
            r_instret <= r_instret + ONE;
         end
         if (w_live & r_halt) begin
            r_halted <= 1'b1;
         end

         if (flush) begin
            r_v    <= 1'b0;
            r_done <= 1'b0;
         end else if (w_stop) begin
            r_v    <= 1'b0;
            r_done <= 1'b0;
         end else if (hold) begin
            r_done <= r_v;
         end else begin
            r_v        <= in_valid;
            r_pc       <= in_pc;
            r_result   <= in_result;
            r_rd       <= in_rd;
            r_regwrite <= in_regwrite;
            r_addr31   <= in_addr31;
            r_halt     <= in_halt;
            r_done     <= 1'b0;
         end
      end
   end

   assign rf_we        = w_live & r_regwrite & w_rd_nz;
   assign rf_wa        = r_rd;
   assign rf_wd        = r_result;

   // Forwarding ignores done: a held entry is still the newest value for rd.
   assign fwd_valid    = r_v & r_regwrite & w_rd_nz;
   assign fwd_rd       = r_rd;
   assign fwd_data     = r_result;

   assign commit_valid = w_live;
   assign commit_pc    = r_pc;
   assign commit_skip  = r_addr31 & w_live;

   assign instret      = r_instret;
   assign halted       = r_halted;

endmodule
